// File: rtl/rv32i_trace_pkg.sv
// Shared encodings for the rv32i pipeline trace monitor: record types, FSM
// states and the packed trace record layout.
package rv32i_trace_pkg;

    typedef enum logic [1:0] {
        TRC_REDIRECT = 2'd0,
        TRC_STALL    = 2'd1,
        TRC_FLUSH    = 2'd2,
        TRC_RSVD     = 2'd3
    } trc_type_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int REC_W = 66;

    typedef struct packed {
        trc_type_e   typ;
        logic [31:0] addr;
        logic [31:0] data;
    } trc_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO succeeds only when a
// pop happens in the same cycle. No write-to-read bypass.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, so the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rv32i_trace_monitor.sv
// Passive observer of rv32i_core pipeline control: classifies events into trace
// records, buffers them for a valid/ready consumer and keeps perf counters.
module rv32i_trace_monitor
    import rv32i_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CAP_LEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_en,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] id_ex_instr,
    input  logic        branch_ex,
    input  logic        branch_taken_ex,
    input  logic [31:0] branch_target,
    input  logic        if_id_flush,
    input  logic        id_ex_flush,
    input  logic        load_stall,
    input  logic        arm,
    input  logic        trig_en,
    input  logic [31:0] trig_pc,
    input  logic        clear,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [1:0]  trc_type,
    output logic [31:0] trc_addr,
    output logic [31:0] trc_data,
    output logic [1:0]  state,
    output logic        overflow,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    localparam int            SW        = $clog2(CAP_LEN + 1);
    localparam logic [SW-1:0] SESS_LAST = SW'(CAP_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    sess_q, sess_d;
    logic             overflow_q;
    logic [31:0]      cycle_cnt_q, instr_cnt_q, stall_cnt_q, redirect_cnt_q;

    logic             redirect, flush, trig_hit, capture;
    logic             ev_valid, push, pop, full, empty;
    trc_rec_t         ev_rec, out_rec;
    logic [REC_W-1:0] fifo_rdata;

    assign redirect = branch_ex & branch_taken_ex;
    assign flush    = if_id_flush | id_ex_flush;
    assign trig_hit = (pc == trig_pc);
    assign capture  = (state_q == ST_CAPTURE) | ((state_q == ST_ARMED) & trig_hit);

    // A flush coinciding with a redirect is folded into the redirect record.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        ev_valid = 1'b0;
        ev_rec   = '0;
        if (redirect) begin
            ev_valid    = 1'b1;
            ev_rec.typ  = TRC_REDIRECT;
            ev_rec.addr = branch_target;
            ev_rec.data = id_ex_instr;
        end else if (load_stall) begin
            ev_valid    = 1'b1;
            ev_rec.typ  = TRC_STALL;
            ev_rec.addr = pc;
            ev_rec.data = if_id_instr;
        end else if (flush) begin
            ev_valid    = 1'b1;
            ev_rec.typ  = TRC_FLUSH;
            ev_rec.addr = pc;
            ev_rec.data = id_ex_instr;
        end
    end

    assign push = ev_valid & capture & ~clear;
    assign pop  = trc_valid & trc_ready;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (ev_rec),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    // Session count advances on every captured event, dropped or not.
    always_comb begin
        state_d = state_q;
        sess_d  = sess_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d = trig_en ? ST_ARMED : ST_CAPTURE;
                    sess_d  = '0;
                end
            end
            ST_ARMED: if (trig_hit) state_d = ST_CAPTURE;
            default: ;
        endcase
        if (push) begin
            sess_d = sess_q + SW'(1);
            if (sess_q == SESS_LAST) state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sess_q         <= '0;
            overflow_q     <= 1'b0;
            cycle_cnt_q    <= '0;
            instr_cnt_q    <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else if (clear) begin
            state_q        <= ST_IDLE;
            sess_q         <= '0;
            overflow_q     <= 1'b0;
            cycle_cnt_q    <= '0;
            instr_cnt_q    <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            sess_q         <= sess_d;
            if (push & full & ~pop) overflow_q <= 1'b1;
            cycle_cnt_q    <= cycle_cnt_q + 32'd1;
            instr_cnt_q    <= instr_cnt_q + {31'd0, pc_en};
            stall_cnt_q    <= stall_cnt_q + {31'd0, load_stall};
            redirect_cnt_q <= redirect_cnt_q + {31'd0, redirect};
        end
    end

    assign trc_valid    = ~empty;
    assign out_rec      = trc_rec_t'(fifo_rdata);
    assign trc_type     = trc_valid ? out_rec.typ  : 2'd0;
    assign trc_addr     = trc_valid ? out_rec.addr : 32'd0;
    assign trc_data     = trc_valid ? out_rec.data : 32'd0;
    assign state        = state_q;
    assign overflow     = overflow_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign instr_cnt    = instr_cnt_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_rv32i_trace_monitor.sv
// Scoreboard bench for rv32i_trace_monitor: a queue-based reference model
// predicts records and counters; a separate monitor checks every handshake.
module tb_rv32i_trace_monitor;
    import rv32i_trace_pkg::*;

    localparam int DEPTH   = 16;
    localparam int CAP_LEN = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, if_id_instr, id_ex_instr, branch_target, trig_pc;
    logic        pc_en, branch_ex, branch_taken_ex, if_id_flush, id_ex_flush;
    logic        load_stall, arm, trig_en, clear, trc_ready;
    logic        trc_valid, overflow;
    logic [1:0]  trc_type, state;
    logic [31:0] trc_addr, trc_data, cycle_cnt, instr_cnt, stall_cnt, redirect_cnt;

    always #5 clk = ~clk;

    rv32i_trace_monitor #(.DEPTH(DEPTH), .CAP_LEN(CAP_LEN)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en),
        .if_id_instr(if_id_instr), .id_ex_instr(id_ex_instr),
        .branch_ex(branch_ex), .branch_taken_ex(branch_taken_ex),
        .branch_target(branch_target), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .load_stall(load_stall), .arm(arm),
        .trig_en(trig_en), .trig_pc(trig_pc), .clear(clear),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_type(trc_type),
        .trc_addr(trc_addr), .trc_data(trc_data), .state(state),
        .overflow(overflow), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          popped = 0;
    logic [1:0]  m_state;
    int          m_sess, m_occ;
    logic        m_ovf;
    logic [31:0] m_cyc, m_ins, m_stl, m_red;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_sess = 0; m_occ = 0; m_ovf = 1'b0;
        m_cyc = '0; m_ins = '0; m_stl = '0; m_red = '0;
        exp_q.delete();
    endtask

    // Behavioural view: session FSM, occupancy count and an ordered record list.
    task automatic model_update();
        logic [1:0] old;
        rec_t       r;
        bit         ev, pop, cap, hit;
        if (clear) begin
            model_reset();
            return;
        end
        old = m_state;
        m_cyc += 1;
        if (pc_en) m_ins += 1;
        if (load_stall) m_stl += 1;
        if (branch_ex && branch_taken_ex) m_red += 1;
        hit = (pc == trig_pc);
        ev  = 1'b1;
        if (branch_ex && branch_taken_ex) r = '{2'd0, branch_target, id_ex_instr};
        else if (load_stall)              r = '{2'd1, pc, if_id_instr};
        else if (if_id_flush || id_ex_flush) r = '{2'd2, pc, id_ex_instr};
        else ev = 1'b0;
        pop = trc_ready && (m_occ > 0);
        cap = (old == ST_CAPTURE) || (old == ST_ARMED && hit);
        if (old == ST_ARMED && hit) m_state = ST_CAPTURE;
        if (cap && ev) begin
            m_sess++;
            if (m_occ < DEPTH || pop) begin
                exp_q.push_back(r);
                m_occ++;
            end else begin
                m_ovf = 1'b1;
            end
            if (m_sess == CAP_LEN) m_state = ST_DONE;
        end
        if ((old == ST_IDLE || old == ST_DONE) && arm) begin
            m_state = trig_en ? ST_ARMED : ST_CAPTURE;
            m_sess  = 0;
        end
        if (pop) m_occ--;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("state", {30'd0, state}, {30'd0, m_state});
        check("valid", {31'd0, trc_valid}, {31'd0, m_occ > 0});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic check_counters();
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("instr_cnt", instr_cnt, m_ins);
        check("stall_cnt", stall_cnt, m_stl);
        check("redirect_cnt", redirect_cnt, m_red);
    endtask

    task automatic quiet();
        pc_en = 0; branch_ex = 0; branch_taken_ex = 0; if_id_flush = 0;
        id_ex_flush = 0; load_stall = 0; arm = 0; clear = 0;
    endtask

    task automatic random_event();
        int k;
        k = $urandom_range(0, 2);
        branch_ex = (k == 0); branch_taken_ex = (k == 0);
        load_stall = (k == 1); id_ex_flush = (k == 2);
        pc = $urandom; if_id_instr = $urandom; id_ex_instr = $urandom;
        branch_target = $urandom;
    endtask

    // Monitor: compares each accepted record and checks hold stability.
    initial begin : monitor
        rec_t        r;
        bit          hold;
        logic [65:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #4;
            if (hold && trc_valid) begin
                check("hold_type", {30'd0, trc_type}, {30'd0, held[65:64]});
                check("hold_addr", trc_addr, held[63:32]);
                check("hold_data", trc_data, held[31:0]);
            end
            if (trc_valid && trc_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rec_unexpected: got addr 0x%08h with nothing expected", trc_addr);
                end else begin
                    r = exp_q.pop_front();
                    popped++;
                    check("rec_type", {30'd0, trc_type}, {30'd0, r.typ});
                    check("rec_addr", trc_addr, r.addr);
                    check("rec_data", trc_data, r.data);
                end
            end
            hold = trc_valid && !trc_ready;
            held = {trc_type, trc_addr, trc_data};
        end
    end

    initial begin : stimulus
        int p0;
        rst = 1'b1; quiet(); trc_ready = 0; trig_en = 0;
        pc = '0; trig_pc = '0; if_id_instr = '0; id_ex_instr = '0; branch_target = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {31'd0, trc_valid}, 32'd0);
        check("rst_type", {30'd0, trc_type}, 32'd0);
        check("rst_addr", trc_addr, 32'd0);
        check("rst_data", trc_data, 32'd0);
        check("rst_state", {30'd0, state}, {30'd0, ST_IDLE});
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check_counters();

        // Arm without trigger, then one taken branch to 0x40.
        arm = 1; tick(); arm = 0;
        branch_ex = 1; branch_taken_ex = 1; branch_target = 32'h40; id_ex_instr = 32'h0000_0063;
        tick(); quiet();
        check("t1_valid", {31'd0, trc_valid}, 32'd1);
        check("t1_type", {30'd0, trc_type}, 32'd0);
        check("t1_addr", trc_addr, 32'h40);
        check("t1_redirect_cnt", redirect_cnt, 32'd1);
        trc_ready = 1; tick(); trc_ready = 0;

        // Triggered session: only the stall at the trigger PC is captured.
        clear = 1; tick(); clear = 0;
        trig_en = 1; trig_pc = 32'h100; arm = 1; pc = 32'h0; tick(); arm = 0;
        pc = 32'h80; load_stall = 1; if_id_instr = 32'h1111_0003; tick();
        load_stall = 0; pc = 32'hC0; tick();
        pc = 32'h100; load_stall = 1; if_id_instr = 32'h2222_0003; tick();
        quiet(); pc = 32'h104;
        check("t2_stall_cnt", stall_cnt, 32'd2);
        check("t2_addr", trc_addr, 32'h100);
        check("t2_type", {30'd0, trc_type}, 32'd1);
        check("t2_state", {30'd0, state}, {30'd0, ST_CAPTURE});
        trc_ready = 1; tick(); tick(); trc_ready = 0;

        // Redirect + flush + stall in one cycle: a single redirect record.
        branch_ex = 1; branch_taken_ex = 1; id_ex_flush = 1; load_stall = 1;
        branch_target = 32'h200; tick(); quiet();
        check("t3_type", {30'd0, trc_type}, 32'd0);
        trc_ready = 1; tick(); trc_ready = 0;
        check("t3_single", {31'd0, trc_valid}, 32'd0);

        // Overflow: 20 stalls into a 16-deep FIFO, then a throttled drain.
        clear = 1; tick(); clear = 0; trig_en = 0; arm = 1; tick(); arm = 0;
        for (int i = 0; i < 20; i++) begin
            load_stall = 1; pc = 32'h1000 + 32'(i * 4); if_id_instr = 32'(i); tick();
        end
        quiet();
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        p0 = popped;
        for (int i = 0; i < 48; i++) begin
            trc_ready = $urandom_range(0, 1); tick();
        end
        trc_ready = 0;
        check("t4_drained", 32'(popped - p0), 32'd16);
        check("t4_sticky", {31'd0, overflow}, 32'd1);

        // Session length: 70 events, capture ends after 64.
        clear = 1; tick(); clear = 0; arm = 1; tick(); arm = 0; trc_ready = 1;
        p0 = popped;
        for (int i = 0; i < 70; i++) begin
            random_event(); tick();
        end
        quiet(); tick(); tick();
        check("t5_done", {30'd0, state}, {30'd0, ST_DONE});
        check("t5_pushes", 32'(popped - p0), 32'd64);
        arm = 1; tick(); arm = 0;
        check("t5_rearm", {30'd0, state}, {30'd0, ST_CAPTURE});
        check_counters();

        // Randomized traffic with triggers and re-arms.
        for (int i = 0; i < 600; i++) begin
            quiet();
            pc_en = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: pc = 32'h104;
                1: pc = 32'h200;
                default: pc = $urandom;
            endcase
            trig_pc = ($urandom_range(0, 1) != 0) ? 32'h104 : 32'h200;
            trig_en = $urandom_range(0, 1);
            arm = ($urandom_range(0, 15) == 0);
            branch_ex = $urandom_range(0, 1); branch_taken_ex = $urandom_range(0, 1);
            load_stall = ($urandom_range(0, 3) == 0);
            if_id_flush = ($urandom_range(0, 5) == 0); id_ex_flush = ($urandom_range(0, 5) == 0);
            if_id_instr = $urandom; id_ex_instr = $urandom; branch_target = $urandom;
            trc_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        quiet();
        check_counters();

        // Async reset in the middle of a capture.
        trig_en = 0; arm = 1; tick(); arm = 0; trc_ready = 0;
        for (int i = 0; i < 3; i++) begin random_event(); tick(); end
        quiet();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, trc_valid}, 32'd0);
        check("rst_mid_state", {30'd0, state}, {30'd0, ST_IDLE});
        check("rst_mid_cycle", cycle_cnt, 32'd0);
        check("rst_mid_stall", stall_cnt, 32'd0);
        model_reset();
        @(negedge clk); rst = 1'b0;

        // Synchronous clear in the middle of a capture.
        arm = 1; tick(); arm = 0;
        for (int i = 0; i < 3; i++) begin random_event(); tick(); end
        quiet(); clear = 1;
        #1 check("clr_valid_before_edge", {31'd0, trc_valid}, 32'd1);
        tick(); clear = 0;
        check("clr_valid", {31'd0, trc_valid}, 32'd0);
        check("clr_state", {30'd0, state}, {30'd0, ST_IDLE});
        check("clr_redirect", redirect_cnt, 32'd0);
        check("clr_cycle", cycle_cnt, 32'd0);

        trc_ready = 1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check_counters();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_trace_monitor.md
Name: rv32i_trace_monitor

Overview:
- Passive on-chip observer for the rv32i_core pipeline debug/hazard ports: pc, pc_en, instruction registers, branch resolution, flush/stall controls.
- Turns pipeline control events into typed trace records, buffers them in a FIFO and drains them over a valid/ready stream.
- Keeps free-running performance counters.
- Sits beside the core at top level. It is the consuming end of the debug interface the core drives.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CAP_LEN, 64, records captured per armed session before the FSM enters DONE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pc  in  32  core fetch PC
- pc_en  in  1  PC register advance enable
- if_id_instr  in  32  IF/ID instruction
- id_ex_instr  in  32  ID/EX instruction
- branch_ex  in  1  branch in EX
- branch_taken_ex  in  1  branch resolved taken
- branch_target  in  32  redirect target
- if_id_flush  in  1  IF/ID flush
- id_ex_flush  in  1  ID/EX flush
- load_stall  in  1  load-use stall
- arm  in  1  one-cycle pulse; starts a capture session
- trig_en  in  1  1 = wait for pc==trig_pc before capturing
- trig_pc  in  32  trigger address
- clear  in  1  synchronous clear of FIFO, counters and FSM
- trc_valid  out  1  record available
- trc_ready  in  1  consumer accepts record
- trc_type  out  2  record type
- trc_addr  out  32  record address field
- trc_data  out  32  record data field
- state  out  2  FSM state
- overflow  out  1  sticky: a record was dropped
- cycle_cnt  out  32  cycles since reset or clear
- instr_cnt  out  32  cycles with pc_en=1
- stall_cnt  out  32  cycles with load_stall=1
- redirect_cnt  out  32  cycles with branch_ex & branch_taken_ex

Behaviour:
- Reset (async) and clear (sync) have the same effect:
  - FIFO empty; trc_valid=0; trc_type/addr/data=0.
  - overflow=0; all counters=0; state=IDLE.
  - clear takes priority over every other input in that cycle.
- Event detection is combinational, one record per cycle at most. Priority:
  - REDIRECT (type 0): branch_ex & branch_taken_ex; addr=branch_target, data=id_ex_instr.
  - STALL (type 1): load_stall; addr=pc, data=if_id_instr.
  - FLUSH (type 2): if_id_flush | id_ex_flush with no redirect; addr=pc, data=id_ex_instr.
  - Type 3 is reserved and never emitted.
  - A flush in the same cycle as a redirect is subsumed into the REDIRECT record.
- FSM states, encoded in the package:
  - IDLE(0): no capture. arm -> ARMED if trig_en=1, else CAPTURE.
  - ARMED(1): no capture. pc==trig_pc -> CAPTURE. Events in the matching cycle are captured.
  - CAPTURE(2): every event is pushed. On the CAP_LEN-th push -> DONE.
  - DONE(3): no capture. arm -> same transitions as from IDLE, and the session record count resets.
  - arm while in ARMED or CAPTURE is ignored.
- The session record count includes dropped records, so a session always ends after CAP_LEN events.
- FIFO behaviour:
  - Show-ahead: a record pushed at edge N appears on trc_valid/trc_* after edge N, i.e. 1-cycle latency.
  - Pop when trc_valid & trc_ready.
  - trc_* must hold stable while trc_valid=1 and trc_ready=0.
- FIFO boundaries:
  - Full and push without pop: record is dropped and overflow is set; it stays set until reset/clear.
  - Full with push and pop in the same cycle: both succeed.
  - Empty with push: the record is not visible in the same cycle (no bypass).
- Counters:
  - Run in every state, independent of the FSM.
  - 32-bit, wrap modulo 2^32.
  - cycle_cnt increments every non-clear cycle.

Decomposition:
- Package rv32i_trace_pkg holds:
  - trace type encodings TRC_REDIRECT/TRC_STALL/TRC_FLUSH;
  - FSM state encodings ST_IDLE/ST_ARMED/ST_CAPTURE/ST_DONE;
  - the record width, 66 bits.
- Sub-module trace_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/full/empty, async reset and sync clear. The top instantiates it once.

Test Plan:
- Reset, then arm with trig_en=0 and branch_ex=branch_taken_ex=1, branch_target=0x00000040 for one cycle -> next cycle trc_valid=1, type=0, addr=0x40; redirect_cnt=1.
- trig_en=1, trig_pc=0x100, arm; load_stall pulsed at pc=0x80, then pc reaches 0x100 with load_stall=1 -> only the stall record at addr=0x100 is captured; stall_cnt=2.
- Same cycle: branch taken, id_ex_flush=1 and load_stall=1 -> exactly one record, type=0.
- DEPTH=16 with trc_ready=0 and 20 consecutive stall events -> 16 records kept, overflow=1. Then raise trc_ready and drain -> records come out in order with trc_* stable while stalled.
- CAP_LEN=64 with 70 events -> state=DONE after the 64th and exactly 64 pushes. A new arm -> CAPTURE again.
- Mid-capture async rst (and separately clear) -> all outputs and counters 0, state=IDLE. trc_valid=0 immediately on rst; on clear at the next edge.
